led_pattern_seq: RTL and testbench

LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

---
 rtl/led_pattern_seq.sv | 69 ++++++
 tb/tb_led_pattern_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: tick-stepped LED pattern sequencer (off / toggle / SOS / heartbeat).
// Define LED_PATTERN_SEQ_PWM_EN to add brightness PWM gating of the LED.
module led_pattern_seq #(
  parameter logic [31:0] SOS_PAT = 32'hA8EE_E2A0,
  parameter logic [31:0] HB_PAT  = 32'hA000_A000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic [1:0] mode,
  input  logic [3:0] brightness,
  output logic       led,
  output logic       tick_out
);
  logic       s1_q, s2_q, s3_q;
  logic       tick_q, tick_d;
  logic [4:0] step_q, step_d;
  logic [1:0] mode_q;
  logic       led_q, led_d;
  logic       pat;
  logic [4:0] idx;
`ifdef LED_PATTERN_SEQ_PWM_EN
  logic [3:0] pwm_q, pwm_d;
`else
  logic       unused_brightness;
  assign unused_brightness = ^brightness;
`endif
  always_comb begin
    tick_d = s2_q & ~s3_q;
    step_d = (mode != mode_q) ? 5'd0 : step_q + {4'd0, tick_d};
    idx    = 5'd31 - step_q;
    pat    = (mode_q == 2'd0) ? 1'b0 :
             (mode_q == 2'd1) ? step_q[0] :
             (mode_q == 2'd2) ? SOS_PAT[idx] : HB_PAT[idx];
`ifdef LED_PATTERN_SEQ_PWM_EN
    pwm_d  = pwm_q + 4'd1;
    led_d  = pat & ((pwm_q < brightness) | (brightness == 4'hF));
`else
    led_d  = pat;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      tick_q <= 1'b0;
      step_q <= 5'd0;
      mode_q <= 2'd0;
      led_q  <= 1'b0;
`ifdef LED_PATTERN_SEQ_PWM_EN
      pwm_q  <= 4'd0;
`endif
    end else begin
      s1_q   <= tick_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      tick_q <= tick_d;
      step_q <= step_d;
      mode_q <= mode;
      led_q  <= led_d;
`ifdef LED_PATTERN_SEQ_PWM_EN
      pwm_q  <= pwm_d;
`endif
    end
  end
  assign led      = led_q;
  assign tick_out = tick_q;
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: scoreboard bench; each tick pushes its expected pulse cycle and LED value.
module tb_led_pattern_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] brightness = 4'hF;
  logic       led, tick_out;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  typedef struct {int cyc; logic led;} exp_t;
  exp_t sb[$];
  logic [31:0] sos_v = 32'b1010_1000_1110_1110_1110_0010_1010_0000;

  led_pattern_seq dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .mode(mode),
    .brightness(brightness), .led(led), .tick_out(tick_out)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input logic exp);
    sb.push_back('{cyc + 3, exp});
    tick_in = 1'b1;
    repeat (6) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every tick_out pulse must match the oldest queued tick.
  initial forever begin
    @(negedge clk);
    if (tick_out) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        @(negedge clk);
        check("pulse_width", int'(tick_out), 0);
        check("led_after_step", int'(led), int'(e.led));
      end
    end
  end

  initial begin
    int n;
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tick_in = ~tick_in;
      #1;
      check("reset_led", int'(led), 0);
      check("reset_tick_out", int'(tick_out), 0);
    end
    @(negedge clk);
    tick_in = 1'b1;
    rst = 1'b1;
    sb.push_back('{cyc + 3, 1'b1});
    repeat (6) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    tick(1'b0);
    tick(1'b1);
    mode = 2'd2;
    repeat (3) @(negedge clk);
    check("sos_step0_led", int'(led), 1);
    for (int k = 1; k <= 35; k++) tick(sos_v[31 - (k % 32)]);
    // Mode 2->3 lands on the same edge as the pulse: clear must win.
    sb.push_back('{cyc + 3, 1'b1});
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    mode = 2'd3;
    repeat (4) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    tick(1'b0);
    tick(1'b1);
    mode = 2'd1;
    repeat (3) @(negedge clk);
`ifdef LED_PATTERN_SEQ_PWM_EN
    brightness = 4'hF;
    tick(1'b1);
    brightness = 4'd4;
    repeat (2) @(negedge clk);
    n = 0;
    for (int i = 0; i < 16; i++) begin @(negedge clk); n += int'(led); end
    check("pwm_b4_duty", n, 4);
    brightness = 4'd0;
    repeat (2) @(negedge clk);
    n = 0;
    for (int i = 0; i < 16; i++) begin @(negedge clk); n += int'(led); end
    check("pwm_b0_duty", n, 0);
    brightness = 4'hF;
    repeat (2) @(negedge clk);
    n = 0;
    for (int i = 0; i < 16; i++) begin @(negedge clk); n += int'(led); end
    check("pwm_b15_duty", n, 16);
    tick(1'b0);
    tick(1'b1);
`else
    brightness = 4'd0;
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    brightness = 4'hF;
    n = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_led", int'(led), 0);
    check("midreset_tick_out", int'(tick_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle_tick", int'(tick_out), 0);
    tick(1'b1);
    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
